// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - assembles one Y86-64 instruction byte-by-byte from a byte-wide synchronous IMEM
//
// Optional feature macro: FETCH_LEN_DECODE_EN
//    defined   : reads stop at the length decoded from byte 0
//    undefined : every fetch reads all 10 bytes (bounds checked on all of them)
//
// Pipeline: byte k is issued in the cycle after edge E(k) and captured at
// edge E(k+2), so one byte per cycle is in flight. cnt_q counts bytes issued;
// pend_q marks that the byte issued last cycle returns on mem_rdata now.

module fetch_sequencer #(
   parameter int IMEM_DEPTH = 1024,
   parameter int ADDR_W     = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [79:0]       instr,
   output logic [3:0]        instr_len,
   output logic [ADDR_W-1:0] valP,
   output logic              instr_valid,
   input  logic              instr_ack,
   output logic              mem_error,
   output logic              instr_err,
   output logic              halted,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_HALT} state_t;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(IMEM_DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              have_len_q, have_len_d;
   logic [3:0]        len_raw_q, len_raw_d;
   logic              err_q, err_d;
   logic [79:0]       instr_q, instr_d;
   logic [3:0]        instr_len_q, instr_len_d;
   logic [ADDR_W-1:0] valp_q, valp_d;
   logic              valid_q, valid_d;
   logic              mem_error_q, mem_error_d;
   logic              instr_err_q, instr_err_d;
   logic              halted_q, halted_d;

   logic [3:0]        ret_k;
   logic              byte0_ret;
   logic [3:0]        cur_len_raw;
   logic              cur_err;
   logic              cur_have;
   logic              cur_halt;
   logic [3:0]        eff_len;
   logic [3:0]        limit;
   logic [ADDR_W:0]   sum_w;
   logic              oor;
   logic              want;
   logic              issue;
   logic              oor_hit;
   logic              last_ret;
   logic [3:0]        len_rep;

   // Byte count of an instruction from its icode; invalid icodes report 1.
   function automatic logic [3:0] len_of(input logic [3:0] icode);
      logic [3:0] l;
      case (icode)
         4'h0, 4'h1, 4'h9:       l = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: l = 4'd2;
         4'h7, 4'h8:             l = 4'd9;
         4'h3, 4'h4, 4'h5:       l = 4'd10;
         default:                l = 4'd1;
      endcase
      return l;
   endfunction

   // Invalid icode/ifun combination check on byte 0.
   function automatic logic err_of(input logic [7:0] b);
      logic e;
      case (b[7:4])
         4'h6:                   e = (b[3:0] > 4'd3);
         4'h2, 4'h7:             e = (b[3:0] > 4'd6);
         4'hC, 4'hD, 4'hE, 4'hF: e = 1'b1;
         default:                e = (b[3:0] != 4'd0);
      endcase
      return e;
   endfunction

   // Issue/capture datapath: length limit, bounds test and read strobe.
   always_comb begin
      ret_k       = cnt_q - 4'd1;
      byte0_ret   = pend_q && (cnt_q == 4'd1);
      cur_len_raw = byte0_ret ? len_of(mem_rdata[7:4]) : len_raw_q;
      cur_err     = byte0_ret ? err_of(mem_rdata) : err_q;
      cur_have    = have_len_q | byte0_ret;
      cur_halt    = byte0_ret ? (mem_rdata == 8'h00) : (instr_q[79:72] == 8'h00);
      eff_len     = cur_err ? 4'd1 : cur_len_raw;
`ifdef FETCH_LEN_DECODE_EN
      limit       = cur_have ? eff_len : 4'd10;
`else
      limit       = 4'd10;
`endif
      sum_w       = {1'b0, pc_q} + {{(ADDR_W-3){1'b0}}, cnt_q};
      oor         = (sum_w >= DEPTH_W);
      want        = (state_q == S_FETCH) && (cnt_q < limit);
      issue       = want && !oor;
      oor_hit     = want && oor;
      last_ret    = (state_q == S_FETCH) && pend_q && (ret_k == limit - 4'd1);
      len_rep     = oor_hit ? (cur_have ? cur_len_raw : 4'd0) : eff_len;
      mem_rd      = issue;
      mem_addr    = issue ? sum_w[ADDR_W-1:0] : '0;
   end

   // Next-state and registered-output computation for the sequencer FSM.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      have_len_d  = have_len_q;
      len_raw_d   = len_raw_q;
      err_d       = err_q;
      instr_d     = instr_q;
      instr_len_d = instr_len_q;
      valp_d      = valp_q;
      valid_d     = valid_q;
      mem_error_d = mem_error_q;
      instr_err_d = instr_err_q;
      halted_d    = halted_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FETCH;
               pc_d       = pc_in;
               cnt_d      = 4'd0;
               pend_d     = 1'b0;
               have_len_d = 1'b0;
               len_raw_d  = 4'd0;
               err_d      = 1'b0;
               instr_d    = '0;
            end
         end
         S_FETCH: begin
            pend_d = issue;
            if (issue) cnt_d = cnt_q + 4'd1;
            for (int k = 0; k < 10; k++) begin
               if (pend_q && (ret_k == 4'(k))) instr_d[79-8*k -: 8] = mem_rdata;
            end
            if (byte0_ret) begin
               have_len_d = 1'b1;
               len_raw_d  = cur_len_raw;
               err_d      = cur_err;
            end
            if (last_ret || oor_hit) begin
               state_d     = S_DONE;
               valid_d     = 1'b1;
               mem_error_d = oor_hit;
               instr_err_d = cur_have && cur_err;
               instr_len_d = len_rep;
               valp_d      = pc_q + {{(ADDR_W-4){1'b0}}, len_rep};
               if (cur_have && cur_halt) halted_d = 1'b1;
            end
         end
         S_DONE: begin
            if (instr_ack) begin
               state_d     = halted_q ? S_HALT : S_IDLE;
               valid_d     = 1'b0;
               mem_error_d = 1'b0;
               instr_err_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         cnt_q       <= 4'd0;
         pend_q      <= 1'b0;
         have_len_q  <= 1'b0;
         len_raw_q   <= 4'd0;
         err_q       <= 1'b0;
         instr_q     <= '0;
         instr_len_q <= 4'd0;
         valp_q      <= '0;
         valid_q     <= 1'b0;
         mem_error_q <= 1'b0;
         instr_err_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         have_len_q  <= have_len_d;
         len_raw_q   <= len_raw_d;
         err_q       <= err_d;
         instr_q     <= instr_d;
         instr_len_q <= instr_len_d;
         valp_q      <= valp_d;
         valid_q     <= valid_d;
         mem_error_q <= mem_error_d;
         instr_err_q <= instr_err_d;
         halted_q    <= halted_d;
      end
   end

   assign instr       = instr_q;
   assign instr_len   = instr_len_q;
   assign valP        = valp_q;
   assign instr_valid = valid_q;
   assign mem_error   = mem_error_q;
   assign instr_err   = instr_err_q;
   assign halted      = halted_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer

module tb_fetch_sequencer;

`ifdef FETCH_LEN_DECODE_EN
   localparam bit LEN_EN = 1'b1;
`else
   localparam bit LEN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [63:0] pc_in = '0;
   logic        mem_rd;
   logic [63:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic [79:0] instr;
   logic [3:0]  instr_len;
   logic [63:0] valP;
   logic        instr_valid;
   logic        instr_ack = 1'b0;
   logic        mem_error;
   logic        instr_err;
   logic        halted;
   logic        busy;

   logic [7:0]  mem [0:1023];
   logic [63:0] rd_log [$];

   int passed = 0;
   int total  = 0;

   fetch_sequencer #(.IMEM_DEPTH(1024), .ADDR_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .instr(instr), .instr_len(instr_len), .valP(valP),
      .instr_valid(instr_valid), .instr_ack(instr_ack),
      .mem_error(mem_error), .instr_err(instr_err),
      .halted(halted), .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous byte memory plus a log of every issued read address.
   always @(posedge clk) begin
      if (mem_rd) begin
         rd_log.push_back(mem_addr);
         if (mem_addr < 64'd1024) mem_rdata <= mem[mem_addr[9:0]];
         else mem_rdata <= 8'hEE;
      end
   end

   function automatic logic [79:0] model_instr(input int pc, input int n);
      logic [79:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[79-8*k -: 8] = mem[pc+k];
      return r;
   endfunction

   task automatic run_fetch(input logic [63:0] pc, output int lat);
      lat = -1;
      @(negedge clk);
      pc_in = pc;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (instr_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      instr_ack = 1'b1;
      @(posedge clk);
      #1 instr_ack = 1'b0;
   endtask

   task automatic check_reads(input string name, input int base, input int pc, input int n);
      bit ok;
      ok = (rd_log.size() - base) == n;
      for (int k = 0; k < n && ok; k++) if (rd_log[base+k] !== 64'(pc + k)) ok = 1'b0;
      total++;
      if (!ok) $display("FAIL %s: %0d reads logged from base, required %0d sequential from %0d", name, rd_log.size() - base, n, pc);
      else passed++;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({mem_rd, mem_addr, instr, instr_len, valP, instr_valid, mem_error, instr_err, halted, busy} !== '0)
         $display("FAIL reset_outputs: got nonzero outputs instr=%h valP=%h busy=%b", instr, valP, busy);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_opq(input string tag);
      int lat, base, n;
      n = LEN_EN ? 2 : 10;
      base = rd_log.size();
      run_fetch(64'd32, lat);
      total++;
      if (lat !== n + 1) $display("FAIL %s_latency: got %0d required %0d", tag, lat, n + 1); else passed++;
      check_reads({tag, "_reads"}, base, 32, n);
      total++;
      if (instr[79:64] !== 16'h6123) $display("FAIL %s_bytes: got %h required 6123", tag, instr[79:64]); else passed++;
      total++;
      if (instr !== model_instr(32, n)) $display("FAIL %s_instr: got %h required %h", tag, instr, model_instr(32, n)); else passed++;
      total++;
      if (instr_len !== 4'd2 || valP !== 64'd34) $display("FAIL %s_len_valp: got %0d/%0d required 2/34", tag, instr_len, valP); else passed++;
      total++;
      if (mem_error !== 1'b0 || instr_err !== 1'b0) $display("FAIL %s_flags: got %b%b required 00", tag, mem_error, instr_err); else passed++;
      do_ack();
      total++;
      if (instr_valid !== 1'b0 || busy !== 1'b0) $display("FAIL %s_ack_idle: got valid=%b busy=%b required 0 0", tag, instr_valid, busy); else passed++;
   endtask

   task automatic test_irmovq();
      int lat, base, after;
      logic [79:0] snap_i;
      logic [63:0] snap_v;
      bit stable;
      base = rd_log.size();
      run_fetch(64'd40, lat);
      total++;
      if (lat !== 11) $display("FAIL irmovq_latency: got %0d required 11", lat); else passed++;
      check_reads("irmovq_reads", base, 40, 10);
      total++;
      if (instr !== 80'h30F2_0102030405060708 || instr_len !== 4'd10 || valP !== 64'd50)
         $display("FAIL irmovq_result: got %h len %0d valP %0d required 30f20102030405060708 10 50", instr, instr_len, valP);
      else passed++;
      snap_i = instr;
      snap_v = valP;
      stable = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (instr !== snap_i || valP !== snap_v || instr_valid !== 1'b1 || instr_len !== 4'd10) stable = 1'b0;
      end
      total++;
      if (!stable) $display("FAIL irmovq_hold: got changing outputs valid=%b required stable", instr_valid); else passed++;
      @(negedge clk);
      instr_ack = 1'b1;
      start = 1'b1;
      pc_in = 64'd32;
      @(posedge clk);
      #1 instr_ack = 1'b0;
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || instr_valid !== 1'b0) $display("FAIL irmovq_ack: got busy=%b valid=%b required 0 0", busy, instr_valid); else passed++;
      after = rd_log.size();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (rd_log.size() !== after || busy !== 1'b0) $display("FAIL ack_cycle_start_ignored: got %0d new reads busy=%b required 0 0", rd_log.size() - after, busy); else passed++;
   endtask

   task automatic test_oor();
      int lat, base;
      base = rd_log.size();
      run_fetch(64'd1020, lat);
      total++;
      if (lat !== 5) $display("FAIL oor_latency: got %0d required 5", lat); else passed++;
      check_reads("oor_reads", base, 1020, 4);
      total++;
      if (mem_error !== 1'b1 || instr_err !== 1'b0) $display("FAIL oor_flags: got %b%b required 10", mem_error, instr_err); else passed++;
      total++;
      if (instr_len !== 4'd10 || valP !== 64'd1030) $display("FAIL oor_len_valp: got %0d/%0d required 10/1030", instr_len, valP); else passed++;
      total++;
      if (instr !== {32'h30F3AABB, 48'h0}) $display("FAIL oor_instr: got %h required 30f3aabb000000000000", instr); else passed++;
      do_ack();
      total++;
      if (mem_error !== 1'b0 || busy !== 1'b0) $display("FAIL oor_ack_clear: got mem_error=%b busy=%b required 0 0", mem_error, busy); else passed++;
   endtask

   task automatic test_instr_err(input int pc, input string tag);
      int lat, base, n;
      n = LEN_EN ? 1 : 10;
      base = rd_log.size();
      run_fetch(64'(pc), lat);
      total++;
      if (lat !== n + 1) $display("FAIL %s_latency: got %0d required %0d", tag, lat, n + 1); else passed++;
      check_reads({tag, "_reads"}, base, pc, n);
      total++;
      if (instr_err !== 1'b1 || mem_error !== 1'b0) $display("FAIL %s_flags: got err=%b memerr=%b required 1 0", tag, instr_err, mem_error); else passed++;
      total++;
      if (instr_len !== 4'd1 || valP !== 64'(pc + 1)) $display("FAIL %s_len_valp: got %0d/%0d required 1/%0d", tag, instr_len, valP, pc + 1); else passed++;
      total++;
      if (instr !== model_instr(pc, n)) $display("FAIL %s_instr: got %h required %h", tag, instr, model_instr(pc, n)); else passed++;
      do_ack();
   endtask

   task automatic test_halt();
      int lat, base, n, after;
      n = LEN_EN ? 1 : 10;
      base = rd_log.size();
      run_fetch(64'd38, lat);
      total++;
      if (lat !== n + 1) $display("FAIL halt_latency: got %0d required %0d", lat, n + 1); else passed++;
      check_reads("halt_reads", base, 38, n);
      total++;
      if (halted !== 1'b1 || instr_len !== 4'd1 || valP !== 64'd39 || instr_err !== 1'b0)
         $display("FAIL halt_result: got halted=%b len=%0d valP=%0d err=%b required 1 1 39 0", halted, instr_len, valP, instr_err);
      else passed++;
      do_ack();
      total++;
      if (busy !== 1'b1 || halted !== 1'b1 || instr_valid !== 1'b0) $display("FAIL halt_state: got busy=%b halted=%b valid=%b required 1 1 0", busy, halted, instr_valid); else passed++;
      after = rd_log.size();
      @(negedge clk);
      pc_in = 64'd32;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (rd_log.size() !== after || instr_valid !== 1'b0 || busy !== 1'b1)
         $display("FAIL halt_ignores_start: got %0d reads valid=%b busy=%b required 0 0 1", rd_log.size() - after, instr_valid, busy);
      else passed++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pc_in = 64'd40;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (mem_rd !== 1'b1 || mem_addr !== 64'd44) $display("FAIL mid_fifth_read: got rd=%b addr=%0d required 1 44", mem_rd, mem_addr); else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({mem_rd, mem_addr, instr, instr_len, valP, instr_valid, mem_error, instr_err, halted, busy} !== '0)
         $display("FAIL mid_reset_outputs: got rd=%b instr=%h busy=%b required all 0", mem_rd, instr, busy);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      test_opq("post_reset_opq");
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[32] = 8'h61; mem[33] = 8'h23;
      mem[38] = 8'h00;
      mem[40] = 8'h30; mem[41] = 8'hF2;
      for (int i = 0; i < 8; i++) mem[42+i] = 8'(i + 1);
      mem[50] = 8'hC0;
      mem[60] = 8'h67;
      mem[1020] = 8'h30; mem[1021] = 8'hF3; mem[1022] = 8'hAA; mem[1023] = 8'hBB;

      test_reset();
      test_opq("opq");
      test_irmovq();
      test_oor();
      test_instr_err(50, "err_c0");
      test_instr_err(60, "err_67");
      test_halt();
      test_reset_mid();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
